// File: rtl/tx_pkg.sv
// Shared widths, FSM encoding and the {I,Q} payload type for the TX sample feeder.
package tx_pkg;

  localparam int unsigned IQ_W   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_word_t;

  // Saturating increment for event counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock show-ahead FIFO: registered RAM write, head word read straight from the read pointer.
module sync_fifo_sc #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned W     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop frees the slot a same-cycle push into a full FIFO lands in
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tx_iq_feeder.sv
// Host byte assembler + prefill-gated sample FIFO feeding the TX chain, with underrun/overflow counters.
module tx_iq_feeder
  import tx_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned AW           = 10,
  parameter int unsigned PREFILL      = 256,
  parameter int unsigned AFULL_MARGIN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_strobe,
  input  logic              frame_sync,
  input  logic              flush,
  input  logic              tsiq_read_strobe,
  output logic [IQ_W-1:0]   tsiq_data,
  output logic              tsiq_valid,
  output logic [AW:0]       fifo_level,
  output logic              tx_almost_full,
  output logic [CNT_W-1:0]  underrun_count,
  output logic [CNT_W-1:0]  overflow_count
);

  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [LW-1:0] AFULL_L   = LW'(DEPTH - AFULL_MARGIN);

  logic [1:0]       byte_idx_q;
  logic [23:0]      shift_q;
  logic [1:0]       idx_eff_c;
  logic             word_done_c;
  iq_word_t         word_c;

  tx_state_e        state_q;
  tx_state_e        state_nxt;
  logic             valid_q;
  logic             valid_nxt;
  logic             afull_q;
  logic             afull_nxt;
  logic [CNT_W-1:0] ur_q;
  logic [CNT_W-1:0] ur_nxt;
  logic [CNT_W-1:0] ov_q;
  logic [CNT_W-1:0] ov_nxt;

  logic             pop_c;
  logic             push_ok_c;
  logic             overflow_c;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nxt;
  logic             full;
  logic             empty;
  logic [IQ_W-1:0]  head;

  // Assembler: frame_sync realigns so the strobed byte becomes I_hi
  assign idx_eff_c   = frame_sync ? 2'd0 : byte_idx_q;
  assign word_done_c = byte_strobe && (idx_eff_c == 2'd3);
  assign word_c      = iq_word_t'({shift_q, byte_data});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else if (flush) begin
      byte_idx_q <= '0;
    end else if (byte_strobe) begin
      byte_idx_q <= idx_eff_c + 2'd1;
      shift_q    <= {shift_q[15:0], byte_data};
    end else if (frame_sync) begin
      byte_idx_q <= '0;
    end
  end

  // valid_q is only ever set with a non-empty FIFO, so it qualifies the pop alone
  assign pop_c      = tsiq_read_strobe && valid_q && !flush;
  assign push_ok_c  = word_done_c && (!full || pop_c) && !flush;
  assign overflow_c = word_done_c && full && !pop_c && !flush;
  assign level_nxt  = flush ? '0 : level + LW'(push_ok_c) - LW'(pop_c);

  sync_fifo_sc #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (IQ_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_ok_c),
    .pop     (pop_c),
    .clear   (flush),
    .wr_data (word_c),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Next state, counters and registered flags
  always_comb begin
    state_nxt = state_q;
    ur_nxt    = ur_q;
    ov_nxt    = ov_q;
    if (flush) begin
      state_nxt = PRIME;
    end else begin
      case (state_q)
        PRIME: if (level >= PREFILL_L) state_nxt = RUN;
        RUN: begin
          if (tsiq_read_strobe && empty) begin
            state_nxt = PRIME;
            ur_nxt    = sat_inc(ur_q);
          end
        end
        default: state_nxt = PRIME;
      endcase
      if (overflow_c) ov_nxt = sat_inc(ov_q);
    end
    valid_nxt = (state_nxt == RUN) && (level_nxt != '0);
    afull_nxt = (level_nxt >= AFULL_L);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PRIME;
      valid_q <= 1'b0;
      afull_q <= 1'b0;
      ur_q    <= '0;
      ov_q    <= '0;
    end else begin
      state_q <= state_nxt;
      valid_q <= valid_nxt;
      afull_q <= afull_nxt;
      ur_q    <= ur_nxt;
      ov_q    <= ov_nxt;
    end
  end

  // Head word is presented in the strobe cycle; masked to zero while not valid
  assign tsiq_data      = valid_q ? head : '0;
  assign tsiq_valid     = valid_q;
  assign fifo_level     = level;
  assign tx_almost_full = afull_q;
  assign underrun_count = ur_q;
  assign overflow_count = ov_q;

endmodule

// File: tb/tb_tx_iq_feeder.sv
// Randomized bench for tx_iq_feeder against a queue-based reference model (PREFILL=256 main, PREFILL=1 aux).
module tb_tx_iq_feeder;

  localparam int DEPTH     = 1024;
  localparam int PREFILL   = 256;
  localparam int AFULL_LVL = 960;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_data;
  logic        byte_strobe;
  logic        frame_sync;
  logic        flush;
  logic        tsiq_read_strobe;

  logic [31:0] tsiq_data;
  logic        tsiq_valid;
  logic [10:0] fifo_level;
  logic        tx_almost_full;
  logic [15:0] underrun_count;
  logic [15:0] overflow_count;

  logic [31:0] p1_data;
  logic        p1_valid;
  logic [10:0] p1_level;
  logic        p1_afull;
  logic [15:0] p1_ur;
  logic [15:0] p1_ov;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  tx_iq_feeder #(.DEPTH(1024), .AW(10), .PREFILL(256), .AFULL_MARGIN(64)) dut (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_strobe(byte_strobe),
    .frame_sync(frame_sync), .flush(flush), .tsiq_read_strobe(tsiq_read_strobe),
    .tsiq_data(tsiq_data), .tsiq_valid(tsiq_valid), .fifo_level(fifo_level),
    .tx_almost_full(tx_almost_full), .underrun_count(underrun_count),
    .overflow_count(overflow_count)
  );

  tx_iq_feeder #(.DEPTH(1024), .AW(10), .PREFILL(1), .AFULL_MARGIN(64)) dut_p1 (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_strobe(byte_strobe),
    .frame_sync(frame_sync), .flush(flush), .tsiq_read_strobe(tsiq_read_strobe),
    .tsiq_data(p1_data), .tsiq_valid(p1_valid), .fifo_level(p1_level),
    .tx_almost_full(p1_afull), .underrun_count(p1_ur), .overflow_count(p1_ov)
  );

  // Reference model of the PREFILL=256 instance: word queue, pending bytes, run flag, counters
  logic [31:0] mq[$];
  logic [7:0]  mb[$];
  bit          m_run;
  int          m_ur;
  int          m_ov;

  task automatic model_step();
    int          lvl;
    int          pos;
    bit          vld;
    bit          pop;
    bit          ur;
    bit          done;
    logic [31:0] w;
    logic [31:0] dropped;
    lvl  = mq.size();
    vld  = m_run && (lvl > 0);
    pop  = tsiq_read_strobe && vld;
    ur   = m_run && tsiq_read_strobe && (lvl == 0);
    pos  = frame_sync ? 0 : mb.size();
    done = byte_strobe && (pos == 3);
    w    = '0;
    if (flush) begin
      mq.delete();
      mb.delete();
      m_run = 1'b0;
    end else begin
      if (frame_sync) mb.delete();
      if (byte_strobe) mb.push_back(byte_data);
      if (done) begin
        w = {mb[0], mb[1], mb[2], mb[3]};
        mb.delete();
      end
      if (pop) dropped = mq.pop_front();
      if (done) begin
        if (lvl < DEPTH || pop) mq.push_back(w);
        else if (m_ov < 65535) m_ov++;
      end
      if (!m_run) m_run = (lvl >= PREFILL);
      else if (ur) begin
        m_run = 1'b0;
        if (m_ur < 65535) m_ur++;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mb.delete();
      m_run = 1'b0;
      m_ur  = 0;
      m_ov  = 0;
    end else begin
      model_step();
    end
  end

  function automatic logic [76:0] dut_obs();
    return {tsiq_valid, tsiq_data, fifo_level, tx_almost_full, underrun_count, overflow_count};
  endfunction

  function automatic logic [76:0] model_obs();
    logic        v;
    logic [31:0] d;
    v = m_run && (mq.size() > 0);
    d = v ? mq[0] : 32'h0;
    return {v, d, 11'(mq.size()), (mq.size() >= AFULL_LVL), 16'(m_ur), 16'(m_ov)};
  endfunction

  // One clock with the given inputs, then back to idle; returns 1 time unit after the edge
  task automatic cyc(input logic s, input logic [7:0] b, input logic fs, input logic rd, input logic fl);
    byte_strobe = s; byte_data = b; frame_sync = fs; tsiq_read_strobe = rd; flush = fl;
    @(posedge clk); #1;
    byte_strobe = 1'b0; frame_sync = 1'b0; tsiq_read_strobe = 1'b0; flush = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rd_last);
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, w[31-8*k -: 8], 1'b0, (k == 3) && rd_last, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; byte_data = '0; byte_strobe = 0; frame_sync = 0; flush = 0; tsiq_read_strobe = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dut_obs() !== 77'h0) $display("FAIL reset_hold: got %h want 0", dut_obs()); else n_pass++;
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (dut_obs() !== 77'h0) $display("FAIL reset_release: got %h want 0", dut_obs()); else n_pass++;
    n_chk++;
    if ({p1_valid, p1_data, p1_level, p1_afull, p1_ur, p1_ov} !== 77'h0)
      $display("FAIL reset_p1: got %h want 0", {p1_valid, p1_data, p1_level, p1_afull, p1_ur, p1_ov});
    else n_pass++;
  endtask

  task automatic test_single_word();
    cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hCD, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({p1_valid, p1_data} !== {1'b1, 32'h1234ABCD})
      $display("FAIL single_word: valid/data=%b/%h want 1/1234abcd", p1_valid, p1_data);
    else n_pass++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({p1_valid, p1_level, p1_data} !== {1'b0, 11'd0, 32'h0})
      $display("FAIL single_pop: valid/level/data=%b/%0d/%h want 0/0/0", p1_valid, p1_level, p1_data);
    else n_pass++;
    n_chk++;
    if (dut_obs() !== model_obs()) $display("FAIL single_main: got %h want %h", dut_obs(), model_obs()); else n_pass++;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_prefill();
    logic [31:0] first;
    first = $urandom();
    send_word(first, 1'b0);
    for (int i = 1; i < 255; i++) begin
      send_word($urandom(), 1'b0);
      n_chk++;
      if (dut_obs() !== model_obs()) $display("FAIL prefill_fill[%0d]: got %h want %h", i, dut_obs(), model_obs()); else n_pass++;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({tsiq_valid, fifo_level} !== {1'b0, 11'd255})
      $display("FAIL prefill_255: valid/level=%b/%0d want 0/255", tsiq_valid, fifo_level);
    else n_pass++;
    send_word($urandom(), 1'b0);
    n_chk++;
    if ({tsiq_valid, fifo_level} !== {1'b0, 11'd256})
      $display("FAIL prefill_256: valid/level=%b/%0d want 0/256", tsiq_valid, fifo_level);
    else n_pass++;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({tsiq_valid, tsiq_data} !== {1'b1, first})
      $display("FAIL prefill_valid: valid/data=%b/%h want 1/%h", tsiq_valid, tsiq_data, first);
    else n_pass++;
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 600 && mq.size() > 1; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_chk++;
      if (dut_obs() !== model_obs()) $display("FAIL drain[%0d]: got %h want %h", i, dut_obs(), model_obs()); else n_pass++;
    end
    n_chk++;
    if ({tsiq_valid, fifo_level} !== {1'b1, 11'd1})
      $display("FAIL drain_one: valid/level=%b/%0d want 1/1", tsiq_valid, fifo_level);
    else n_pass++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({tsiq_valid, fifo_level, underrun_count} !== {1'b0, 11'd0, 16'd0})
      $display("FAIL last_pop: valid/level/ur=%b/%0d/%0d want 0/0/0", tsiq_valid, fifo_level, underrun_count);
    else n_pass++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({tsiq_valid, underrun_count} !== {1'b0, 16'd1})
      $display("FAIL underrun: valid/ur=%b/%0d want 0/1", tsiq_valid, underrun_count);
    else n_pass++;
    send_word($urandom(), 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({tsiq_valid, fifo_level, tsiq_data} !== {1'b0, 11'd1, 32'h0})
      $display("FAIL reprime: valid/level/data=%b/%0d/%h want 0/1/0", tsiq_valid, fifo_level, tsiq_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      send_word($urandom(), 1'b0);
      if (i % 64 == 63) begin
        n_chk++;
        if (dut_obs() !== model_obs()) $display("FAIL fill[%0d]: got %h want %h", i, dut_obs(), model_obs()); else n_pass++;
      end
    end
    n_chk++;
    if ({fifo_level, tx_almost_full, overflow_count} !== {11'd1024, 1'b1, 16'd0})
      $display("FAIL full: level/afull/ov=%0d/%b/%0d want 1024/1/0", fifo_level, tx_almost_full, overflow_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) send_word($urandom(), 1'b0);
    n_chk++;
    if ({fifo_level, overflow_count} !== {11'd1024, 16'd3})
      $display("FAIL overflow: level/ov=%0d/%0d want 1024/3", fifo_level, overflow_count);
    else n_pass++;
    send_word($urandom(), 1'b1);
    n_chk++;
    if ({fifo_level, overflow_count} !== {11'd1024, 16'd3})
      $display("FAIL push_pop_full: level/ov=%0d/%0d want 1024/3", fifo_level, overflow_count);
    else n_pass++;
    n_chk++;
    if (dut_obs() !== model_obs()) $display("FAIL push_pop_model: got %h want %h", dut_obs(), model_obs()); else n_pass++;
  endtask

  task automatic test_frame_sync();
    logic [7:0]  b [6];
    logic [31:0] exp_w;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom());
    exp_w = {b[2], b[3], b[4], b[5]};
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, b[0], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, b[1], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, b[2], 1'b1, 1'b0, 1'b0);
    cyc(1'b1, b[3], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, b[4], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, b[5], 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (fifo_level !== 11'd1) $display("FAIL fsync_level: got %0d want 1", fifo_level); else n_pass++;
    for (int i = 0; i < 255; i++) send_word($urandom(), 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({tsiq_valid, tsiq_data} !== {1'b1, exp_w})
      $display("FAIL fsync_word: valid/data=%b/%h want 1/%h", tsiq_valid, tsiq_data, exp_w);
    else n_pass++;
    for (int i = 0; i < 300 && mq.size() > 100; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({tsiq_valid, fifo_level} !== {1'b1, 11'd100})
      $display("FAIL pre_flush: valid/level=%b/%0d want 1/100", tsiq_valid, fifo_level);
    else n_pass++;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({tsiq_valid, fifo_level, underrun_count, overflow_count} !== {1'b0, 11'd0, 16'd1, 16'd3})
      $display("FAIL flush: valid/level/ur/ov=%b/%0d/%0d/%0d want 0/0/1/3", tsiq_valid, fifo_level, underrun_count, overflow_count);
    else n_pass++;
    send_word($urandom(), 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({tsiq_valid, fifo_level} !== {1'b0, 11'd1})
      $display("FAIL flush_prime: valid/level=%b/%0d want 0/1", tsiq_valid, fifo_level);
    else n_pass++;
  endtask

  task automatic test_random();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      int rd_pct;
      rd_pct = (i < 2000) ? 5 : 35;
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom()), 1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 999) == 0));
      n_chk++;
      if (dut_obs() !== model_obs()) $display("FAIL random[%0d]: got %h want %h", i, dut_obs(), model_obs()); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = $urandom();
    send_word($urandom(), 1'b0);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (dut_obs() !== 77'h0) $display("FAIL async_reset: got %h want 0", dut_obs()); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b1, w[31-8*k -: 8], 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({p1_valid, p1_data, p1_level} !== {1'b1, w, 11'd1})
      $display("FAIL realign_after_reset: valid/data/level=%b/%h/%0d want 1/%h/1", p1_valid, p1_data, p1_level, w);
    else n_pass++;
    n_chk++;
    if (dut_obs() !== model_obs()) $display("FAIL reset_mid_main: got %h want %h", dut_obs(), model_obs()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_prefill();
    test_underrun();
    test_overflow();
    test_frame_sync();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
